// File: rtl/countdown_pkg.sv
// Shared types and defaults for the countdown timer family.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned COUNTDOWN_N = 4;

endpackage

// File: rtl/countdown_timer_n_bit.sv
// Loadable n-bit down-counting timer with one-cycle terminal-count pulse
// and optional auto-reload; all outputs are registered.
module countdown_timer_n_bit
  import countdown_pkg::*;
#(
  parameter int unsigned n = COUNTDOWN_N
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [n-1:0] load_data,
  input  logic         start,
  input  logic         stop,
  input  logic         en,
  input  logic         auto_reload,
  output logic [n-1:0] count,
  output logic         tc,
  output logic         busy,
  output logic         done
);

  localparam logic [n-1:0] ONE = {{(n-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [n-1:0] count_q, count_d;
  logic [n-1:0] reload_q, reload_d;
  logic         tc_q, tc_d;

  // Priority: load > stop > start > run behaviour.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load) begin
      reload_d = load_data;
      count_d  = load_data;
      state_d  = IDLE;
    end else if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      count_d = reload_q;
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (en) begin
            if (count_q != '0) begin
              count_d = count_q - ONE;
            end else begin
              // Terminal event: decrement is suppressed, so count never wraps.
              tc_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                state_d = DONE;
              end
            end
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_countdown_timer_n_bit.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an elapsed-cycle model.
module tb_countdown_timer_n_bit;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         resetn;
  logic         load, start, stop, en, auto_reload;
  logic [N-1:0] load_data;
  logic [N-1:0] count;
  logic         tc, busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 1'b0;

  countdown_timer_n_bit #(.n(N)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .load       (load),
    .load_data  (load_data),
    .start      (start),
    .stop       (stop),
    .en         (en),
    .auto_reload(auto_reload),
    .count      (count),
    .tc         (tc),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Model: in running mode the count is reload minus the enabled cycles
  // elapsed in the current period; otherwise a held value is shown.
  int m_reload  = 0;
  int m_held    = 0;
  int m_elapsed = 0;
  int m_mode    = 0;  // 0 idle, 1 running, 2 finished
  bit m_tc      = 1'b0;

  function automatic int exp_count();
    return (m_mode == 1) ? (m_reload - m_elapsed) : m_held;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_reload = 0; m_held = 0; m_elapsed = 0; m_mode = 0; m_tc = 1'b0;
    end else begin
      m_tc = 1'b0;
      if (load) begin
        m_reload = int'(load_data);
        m_held   = int'(load_data);
        m_mode   = 0;
      end else if (stop) begin
        if (m_mode == 1) m_held = m_reload - m_elapsed;
        m_mode = 0;
      end else if (start) begin
        m_mode    = 1;
        m_elapsed = 0;
      end else if (m_mode == 1 && en) begin
        if (m_elapsed == m_reload) begin
          m_tc = 1'b1;
          if (auto_reload) m_elapsed = 0;
          else begin
            m_mode = 2;
            m_held = 0;
          end
        end else begin
          m_elapsed = m_elapsed + 1;
        end
      end
    end
  end

  function automatic void chk(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_count", int'(count), exp_count());
      chk("model_tc",    int'(tc),    int'(m_tc));
      chk("model_busy",  int'(busy),  (m_mode == 1) ? 1 : 0);
      chk("model_done",  int'(done),  (m_mode == 2) ? 1 : 0);
    end
  end

  // Called at a falling edge: drive inputs, advance to the next falling edge.
  task automatic step(input logic l, input int ld, input logic sa,
                      input logic so, input logic e, input logic ar);
    load        = l;
    load_data   = ld[N-1:0];
    start       = sa;
    stop        = so;
    en          = e;
    auto_reload = ar;
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input int c, input int t,
                            input int b, input int d);
    chk({tag, "_count"}, int'(count), c);
    chk({tag, "_tc"},    int'(tc),    t);
    chk({tag, "_busy"},  int'(busy),  b);
    chk({tag, "_done"},  int'(done),  d);
  endtask

  initial begin
    resetn = 1'b0;
    load = 0; start = 0; stop = 0; en = 0; auto_reload = 0; load_data = '0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    cmp_on = 1'b1;
    expect_out("reset", 0, 0, 0, 0);

    // Reset mid-run
    step(1, 9, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    expect_out("rst_start", 9, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    expect_out("rst_run", 6, 0, 1, 0);
    #2 resetn = 1'b0;
    #1 expect_out("rst_async", 0, 0, 0, 0);
    @(negedge clk);
    resetn = 1'b1;
    step(0, 0, 0, 0, 1, 0);
    expect_out("rst_idle", 0, 0, 0, 0);

    // One-shot
    step(1, 3, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    expect_out("os_3", 3, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0); expect_out("os_2", 2, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0); expect_out("os_1", 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0); expect_out("os_0", 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0); expect_out("os_tc", 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0); expect_out("os_hold", 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0); expect_out("os_hold2", 0, 0, 0, 1);

    // Auto-reload with pause
    step(1, 2, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1, 1); expect_out("ar_2", 2, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1); expect_out("ar_1", 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1); expect_out("ar_pause", 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1); expect_out("ar_0", 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1); expect_out("ar_tc", 2, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1); expect_out("ar_after", 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1); expect_out("ar_0b", 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1); expect_out("ar_tc2", 2, 1, 1, 0);

    // Priority: load beats stop and start
    step(1, 8, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    expect_out("pri_5", 5, 0, 1, 0);
    step(1, 7, 1, 1, 1, 0); expect_out("pri_load", 7, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0); expect_out("pri_start", 7, 0, 1, 0);

    // Zero reload: tc every enabled cycle
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1); expect_out("z_start", 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 1);
      expect_out("z_tc", 0, 1, 1, 0);
    end
    step(0, 0, 0, 0, 0, 1); expect_out("z_pause", 0, 0, 1, 0);

    // Stop and restart
    step(1, 15, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0); expect_out("sr_15", 15, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
    expect_out("sr_11", 11, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0); expect_out("sr_stop", 11, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0); expect_out("sr_held", 11, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0); expect_out("sr_restart", 15, 0, 1, 0);

    // Randomized traffic, checked by the per-cycle compare process
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        load = 0; start = 0; stop = 0; en = 0;
        #2 resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
      end else begin
        step(logic'($urandom_range(0, 99) < 4),
             int'($urandom_range(0, 15)),
             logic'($urandom_range(0, 99) < 6),
             logic'($urandom_range(0, 99) < 3),
             logic'($urandom_range(0, 99) < 75),
             logic'($urandom_range(0, 1)));
      end
    end

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer_n_bit.md
# countdown_timer_n_bit

- Parameterised n-bit down-counting timer.
- A load captures a reload value, and start begins decrementing toward zero on enabled cycles.
- Reaching zero raises a one-cycle terminal-count pulse. The timer then stops in DONE or, in auto-reload mode, restarts from the stored value.
- It pairs with the team's loadable up-counters: those produce counts, while this block consumes a programmed interval and signals its expiry.

## Interface
- n, 4, counter and reload width (n >= 2)

- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- load  input  1  capture load_data into reload register and count; forces IDLE
- load_data  input  n  reload value
- start  input  1  begin or restart countdown from reload value
- stop  input  1  abort countdown, return to IDLE, count held
- en  input  1  decrement qualifier while running; low = pause
- auto_reload  input  1  sampled at terminal count: 1 = reload and keep running, 0 = go to DONE
- count  output  n  current count value
- tc  output  1  registered one-cycle terminal-count pulse
- busy  output  1  high in RUN
- done  output  1  high in DONE

## Operation
- Reset (async, resetn low): state IDLE, count 0, reload register 0, tc 0, busy 0, done 0.
- States: IDLE, RUN, DONE. busy = (state==RUN), done = (state==DONE), decoded from registered state.
- Priority per edge: resetn > load > stop > start > run behaviour.
- load (any state): reload <= load_data, count <= load_data, state <= IDLE, tc <= 0. start and stop are ignored that cycle.
- stop (no load): state <= IDLE, count unchanged, tc <= 0.
- start from IDLE or DONE: count <= reload, state <= RUN.
- start in RUN (restart): count <= reload, stays RUN, no tc.
- RUN with en=0: count holds, tc <= 0.
- RUN with en=1 and count != 0: count <= count - 1, tc <= 0.
- RUN with en=1 and count == 0 (terminal event): tc <= 1.
  - auto_reload=1: count <= reload, stays RUN.
  - auto_reload=0: count stays 0, state <= DONE.
- Period: a reload value R gives one tc every R+1 enabled cycles. R=0 gives tc on every enabled cycle in auto-reload mode.
- Arithmetic is n-bit unsigned. count never wraps below 0, because the decrement is suppressed at 0.
- DONE holds count 0 until start, load, or stop. stop in DONE returns to IDLE with count 0.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- load, start, and stop take effect at the next rising edge and are visible on outputs in the following cycle.
- tc is high for exactly one cycle: the cycle after the edge that processed the terminal event.
  - Auto-reload: count already equals reload while tc is high.
  - One-shot: done rises in the same cycle as tc.
- Back-to-back tc (R=0, auto_reload=1, en=1) is legal: tc stays high continuously, once per cycle.
- resetn deasserting mid-run: the block restarts in IDLE. There is no resume.

## Structure
- Shared package countdown_pkg:
  - typedef enum logic [1:0] state_t {IDLE, RUN, DONE};
  - default width constant COUNTDOWN_N = 4.
- Single always_ff block for state, count, reload, and tc; combinational decode for busy and done.
- No sub-module; the reload register and the decrementer are too small to justify one.

## Test plan
- Reset mid-run: n=4, load 9, start, run 3 cycles, assert resetn low asynchronously. Required: count=0, busy=0, done=0, tc=0 immediately. After release the block sits in IDLE.
- One-shot: load 3, start, en=1, auto_reload=0. Required: count goes 3,2,1,0, then tc=1 and done=1 on the next cycle. tc drops after one cycle, done stays high, count stays 0.
- Auto-reload with pause: load 2, auto_reload=1, start, en toggled 1,0,1,1,1. Required: count 2,1,1,0 then tc with count=2. tc period is 3 enabled cycles.
- Priority: in RUN with count=5, assert load (load_data=7), stop, and start in one cycle. Required: count=7, state IDLE, busy=0. Next: start alone gives busy=1, count=7.
- Zero reload: load 0, auto_reload=1, start, en=1 for 4 cycles. Required: tc high on 4 consecutive cycles, count constant 0.
- Stop and restart: load 15, start, run 4 enabled cycles to count=11, then stop. Required: count=11, busy=0. Then start: count=15, busy=1.
